data_stream_mux: RTL and testbench
==================================

# data_stream_mux

Time-division multiplexer that merges three parallel data streams (DS1, DS2, DS3) onto one output bus, advancing on ticks of a symbol-rate strobe. The mode input selects single-stream pass-through, DS1/DS2 alternation, or DS1/DS2/DS3 rotation. A programmable dwell count sets how many symbols each stream occupies. It sits between the stream sources and the symbol-rate transmit path, and runs entirely in the system clock domain.

## Interface
- DATA_W, 3: width of each stream and of the output.
- CNT_W, 2: width of switch_clk_cycles and of the internal dwell counter.

- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- symbol_clk  input  1  symbol strobe, synchronous to clk (a level signal, not a clock); each 0→1 transition is one symbol tick.
- switch_clk_cycles  input  CNT_W  dwell, in symbol ticks, per stream before switching.
- DS1, DS2, DS3  input  DATA_W each  stream data.
- mode  input  2  0 = idle, 1 = DS1 only, 2 = DS1/DS2 alternate, 3 = DS1/DS2/DS3 rotate.
- multiplexed_data  output  DATA_W  registered multiplexed output.

## Operation
- sym_q registers symbol_clk every cycle. tick = symbol_clk & ~sym_q.
- State:
  - sel ∈ {S1, S2, S3}: the current stream.
  - cnt: the dwell counter, CNT_W bits.
  - mode_q: the registered mode.
- Effective dwell D = switch_clk_cycles, except that 0 is treated as 1.
- Inputs wider than CNT_W are truncated by the connecting logic. For example, 6 on a 2-bit port becomes 2.
- On a tick, with mode unchanged:
  - multiplexed_data <= stream[sel], where S1→DS1, S2→DS2, S3→DS3. In mode 0 it loads 0.
  - If cnt+1 >= D: cnt <= 0 and sel advances. Otherwise cnt <= cnt+1.
- Sequences:
  - Mode 1: sel is held at S1.
  - Mode 2: S1→S2→S1.
  - Mode 3: S1→S2→S3→S1.
  - Mode 0: sel is held at S1 and the output loads 0 on each tick.
- Comparison is >=. If D shrinks mid-dwell, the dwell ends on the next tick and the counter never overruns.
- Mode change (mode != mode_q):
  - On that clk edge: mode_q <= mode, sel <= S1, cnt <= 0, and multiplexed_data holds.
  - A tick on the same edge is consumed without loading. The new sequence starts at the next tick.
- Between ticks, multiplexed_data holds. Stream inputs are sampled only on tick edges.

## Timing
- Reset (rst_n low at a clk edge) sets:
  - multiplexed_data = 0
  - sel = S1, cnt = 0
  - sym_q = 0, mode_q = 0
- Reset has priority over ticks and mode changes.
- Reset mid-dwell restarts the sequence at DS1.
- After reset deasserts, symbol_clk already high does not produce a tick. It must first be sampled low.
- Latency: the output updates on the same clk edge at which symbol_clk is first sampled high after being sampled low. This is 1 cycle after the symbol_clk rise, counted as a combinational-to-register path.
- Minimum symbol period is 2 clk cycles (high ≥1, low ≥1). A constant-high symbol_clk produces no further ticks.
- Each stream occupies exactly D consecutive tick-updates.
- Cycle lengths:
  - Mode 2: 2·D ticks.
  - Mode 3: 3·D ticks.

## Test plan
Common setup: clk period 10 ns; symbol_clk toggles every 10 ns, so one tick per 2 clk cycles.

- Reset: hold rst_n=0 for 3 cycles with symbol_clk toggling → multiplexed_data=000. On release, the first tick loads DS1.
- Mode 1: DS1=101, DS2=110, DS3=111, switch_clk_cycles=6 (truncated to 2) → every tick outputs 101, and 110/111 never appear.
- Mode 2: switch_clk_cycles=3 → output 101,101,101,110,110,110,101,… Switch points fall exactly every 3 ticks.
- Mode 3: switch_clk_cycles=2 → output 101,101,110,110,111,111,101,… Cycle length is 6 ticks.
- Mid-run changes:
  - Switch from mode 3 to mode 2 partway through a DS3 dwell → output holds on the change edge, then the next tick outputs 101 and the sequence restarts.
  - switch_clk_cycles=0 → DS alternates every tick.
- Reset mid-operation: assert rst_n=0 during a DS2 dwell in mode 2 → output goes to 000 on that edge. The sequence resumes with DS1 for a full D ticks.

Source files
------------

// File: rtl/data_stream_mux.sv
// Time-division multiplexer that merges three streams onto one bus, advancing on symbol ticks.
// The mode input picks pass-through, two-stream alternation or three-stream rotation; each stream dwells D ticks.
module data_stream_mux #(
  parameter int unsigned DATA_W = 3,
  parameter int unsigned CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              symbol_clk,
  input  logic [CNT_W-1:0]  switch_clk_cycles,
  input  logic [DATA_W-1:0] DS1,
  input  logic [DATA_W-1:0] DS2,
  input  logic [DATA_W-1:0] DS3,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] multiplexed_data
);

  localparam int unsigned CNT_W1 = CNT_W + 1;

  localparam logic [1:0] S1 = 2'd0;
  localparam logic [1:0] S2 = 2'd1;
  localparam logic [1:0] S3 = 2'd2;

  localparam logic [1:0] MODE_IDLE = 2'd0;
  localparam logic [1:0] MODE_ALT  = 2'd2;
  localparam logic [1:0] MODE_ROT  = 2'd3;

  logic              sym_q;
  logic              armed;
  logic [1:0]        mode_q;
  logic [1:0]        sel;
  logic [CNT_W-1:0]  cnt;

  logic              tick;
  logic [CNT_W-1:0]  dwell;
  logic [CNT_W1-1:0] cnt_inc;
  logic              dwell_done;
  logic [1:0]        sel_adv;
  logic [1:0]        sel_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [1:0]        mode_q_nxt;
  logic [DATA_W-1:0] data_nxt;

  // A tick needs symbol_clk to have been genuinely sampled low since reset.
  always_comb begin
    tick       = symbol_clk & ~sym_q & armed;
    dwell      = (switch_clk_cycles == '0) ? CNT_W'(1) : switch_clk_cycles;
    cnt_inc    = {1'b0, cnt} + CNT_W1'(1);
    dwell_done = (cnt_inc >= {1'b0, dwell});
  end

  always_comb begin
    sel_adv = S1;
    case (mode_q)
      MODE_ALT: sel_adv = (sel == S1) ? S2 : S1;
      MODE_ROT: begin
        case (sel)
          S1:      sel_adv = S2;
          S2:      sel_adv = S3;
          default: sel_adv = S1;
        endcase
      end
      default:  sel_adv = S1;
    endcase
  end

  // Next-state: a mode change restarts the sequence and swallows any coincident tick.
  always_comb begin
    sel_nxt    = sel;
    cnt_nxt    = cnt;
    mode_q_nxt = mode_q;
    data_nxt   = multiplexed_data;
    if (mode != mode_q) begin
      mode_q_nxt = mode;
      sel_nxt    = S1;
      cnt_nxt    = '0;
    end else if (tick) begin
      case (sel)
        S2:      data_nxt = DS2;
        S3:      data_nxt = DS3;
        default: data_nxt = DS1;
      endcase
      if (mode_q == MODE_IDLE) data_nxt = '0;
      if (dwell_done) begin
        cnt_nxt = '0;
        sel_nxt = sel_adv;
      end else begin
        cnt_nxt = cnt_inc[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sym_q            <= 1'b0;
      armed            <= 1'b0;
      mode_q           <= MODE_IDLE;
      sel              <= S1;
      cnt              <= '0;
      multiplexed_data <= '0;
    end else begin
      sym_q            <= symbol_clk;
      armed            <= armed | ~symbol_clk;
      mode_q           <= mode_q_nxt;
      sel              <= sel_nxt;
      cnt              <= cnt_nxt;
      multiplexed_data <= data_nxt;
    end
  end

endmodule

// File: tb/tb_data_stream_mux.sv
// Self-checking bench for data_stream_mux: directed scenarios followed by randomized traffic,
// compared cycle by cycle against a slot/dwell reference model.
module tb_data_stream_mux;

  localparam int unsigned DATA_W = 3;
  localparam int unsigned CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              symbol_clk;
  logic [CNT_W-1:0]  switch_clk_cycles;
  logic [DATA_W-1:0] DS1, DS2, DS3;
  logic [1:0]        mode;
  logic [DATA_W-1:0] multiplexed_data;

  int total = 0;
  int bad   = 0;

  bit sym_run;

  // reference model state
  bit              m_prev_sym;
  bit              m_seen_low;
  int              m_mode;
  int              m_slot;
  int              m_used;
  logic [DATA_W-1:0] m_out;

  data_stream_mux #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .symbol_clk        (symbol_clk),
    .switch_clk_cycles (switch_clk_cycles),
    .DS1               (DS1),
    .DS2               (DS2),
    .DS3               (DS3),
    .mode              (mode),
    .multiplexed_data  (multiplexed_data)
  );

  always #5 clk = ~clk;

  function automatic int n_streams(input int md);
    return (md == 3) ? 3 : (md == 2) ? 2 : 1;
  endfunction

  function automatic logic [DATA_W-1:0] pick(input int slot);
    logic [DATA_W-1:0] v;
    case (slot)
      1:       v = DS2;
      2:       v = DS3;
      default: v = DS1;
    endcase
    return v;
  endfunction

  task automatic model_edge();
    int d;
    bit tk;
    if (!rst_n) begin
      m_prev_sym = 0; m_seen_low = 0; m_mode = 0;
      m_slot = 0; m_used = 0; m_out = '0;
    end else begin
      d  = (int'(switch_clk_cycles) == 0) ? 1 : int'(switch_clk_cycles);
      tk = symbol_clk && !m_prev_sym && m_seen_low;
      if (int'(mode) != m_mode) begin
        m_mode = int'(mode); m_slot = 0; m_used = 0;
      end else if (tk) begin
        m_out = (m_mode == 0) ? '0 : pick(m_slot);
        m_used++;
        if (m_used >= d) begin
          m_used = 0;
          m_slot = (m_slot + 1) % n_streams(m_mode);
        end
      end
      m_prev_sym = symbol_clk;
      if (!symbol_clk) m_seen_low = 1;
    end
  endtask

  task automatic check(input string tag, input logic [DATA_W-1:0] exp);
    total++;
    assert (multiplexed_data === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, multiplexed_data, exp);
    end
  endtask

  task automatic step(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      check(tag, m_out);
      if (sym_run) symbol_clk = ~symbol_clk;
    end
  endtask

  initial begin
    rst_n = 1'b0; symbol_clk = 1'b0; sym_run = 1;
    mode = 2'd1; switch_clk_cycles = CNT_W'(6);
    DS1 = 3'b101; DS2 = 3'b110; DS3 = 3'b111;

    // reset held with symbol_clk toggling, then mode 1 pass-through
    step("reset", 3);
    check("reset_zero", 3'b000);
    rst_n = 1'b1;
    step("mode1", 12);
    check("mode1_ds1", 3'b101);

    mode = 2'd2; switch_clk_cycles = 2'd3;
    step("mode2", 28);

    mode = 2'd3; switch_clk_cycles = 2'd2;
    step("mode3", 26);
    for (int i = 0; i < 20 && m_slot != 2; i++) step("mode3_seek", 1);
    step("mode3_in_ds3", 2);
    mode = 2'd2;
    step("mode3to2", 12);

    switch_clk_cycles = 2'd0;
    step("dwell0", 14);
    switch_clk_cycles = 2'd3;
    step("dwell3", 10);
    switch_clk_cycles = 2'd1;
    step("dwell_shrink", 8);

    // reset during a DS2 dwell
    switch_clk_cycles = 2'd3;
    for (int i = 0; i < 30 && !(m_slot == 1 && m_used == 1); i++) step("seek_ds2", 1);
    rst_n = 1'b0;
    step("mid_reset", 1);
    check("mid_reset_zero", 3'b000);
    rst_n = 1'b1;
    step("after_reset", 20);

    // release reset with symbol_clk stuck high: no tick until it goes low
    rst_n = 1'b0; sym_run = 0; symbol_clk = 1'b1;
    step("reset_hi", 2);
    rst_n = 1'b1;
    step("stuck_hi", 4);
    check("stuck_hi_zero", 3'b000);
    symbol_clk = 1'b0; sym_run = 1;
    step("resume", 8);

    mode = 2'd0;
    step("idle", 8);
    check("idle_zero", 3'b000);

    // randomized traffic
    sym_run = 0;
    for (int i = 0; i < 600; i++) begin
      DS1 = DATA_W'($urandom); DS2 = DATA_W'($urandom); DS3 = DATA_W'($urandom);
      symbol_clk = $urandom_range(1, 0) == 1;
      if ($urandom_range(40, 0) == 0) mode = 2'($urandom);
      if ($urandom_range(30, 0) == 0) switch_clk_cycles = CNT_W'($urandom);
      rst_n = ($urandom_range(150, 0) != 0);
      step("random", 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
